// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default datapath sizes, result-source indices and
// the writeback FSM state encoding.
`default_nettype none

package tpu_pkg;

  localparam int DWIDTH_DEF   = 8;
  localparam int AWIDTH_DEF   = 10;
  localparam int MAT_SIZE_DEF = 4;
  localparam int NUM_SRC_DEF  = 4;

  localparam int SRC_MATMUL = 0;
  localparam int SRC_NORM   = 1;
  localparam int SRC_ACT    = 2;
  localparam int SRC_POOL   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_addr_gen.sv
// Writeback address generator: running write address, stride add and row
// counter, flagging the final row of the job.
`default_nettype none

module wb_addr_gen #(
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH-1:0] stride,
  input  logic [7:0]        num_rows,
  output logic [AWIDTH-1:0] next_addr,
  output logic              last_row
);

  logic [AWIDTH-1:0] stride_q;
  logic [7:0]        rows_q;
  logic [7:0]        row_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      next_addr <= '0;
      stride_q  <= '0;
      rows_q    <= '0;
      row_cnt   <= '0;
    end else if (load) begin
      next_addr <= base_addr;
      stride_q  <= stride;
      rows_q    <= num_rows;
      row_cnt   <= '0;
    end else if (advance) begin
      // Address wraps modulo 2^AWIDTH by plain truncation.
      next_addr <= next_addr + stride_q;
      row_cnt   <= row_cnt + 8'd1;
    end
  end

  assign last_row = (row_cnt == (rows_q - 8'd1));

endmodule

`default_nettype wire

// File: rtl/result_writeback.sv
// Result writeback: selects one result source and streams its rows into BRAM
// at base + k*stride, masking unused lanes of the final row.
`default_nettype none

module result_writeback
  import tpu_pkg::*;
#(
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int MAT_SIZE = MAT_SIZE_DEF,
  parameter int AWIDTH   = AWIDTH_DEF,
  parameter int NUM_SRC  = NUM_SRC_DEF
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [AWIDTH-1:0]                        base_addr,
  input  logic [AWIDTH-1:0]                        stride,
  input  logic [7:0]                               num_rows,
  input  logic [$clog2(MAT_SIZE):0]                last_lanes,
  input  logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] src_sel,
  input  logic [NUM_SRC*MAT_SIZE*DWIDTH-1:0]       src_data,
  input  logic [NUM_SRC-1:0]                       src_valid,
  output logic [AWIDTH-1:0]                        bram_addr,
  output logic [MAT_SIZE*DWIDTH-1:0]               bram_wdata,
  output logic [MAT_SIZE-1:0]                      bram_we,
  output logic                                     bram_en,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     drop_err
);

  localparam int ROW_W  = MAT_SIZE * DWIDTH;
  localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LANE_W = $clog2(MAT_SIZE) + 1;

  wb_state_t         state, state_nxt;
  logic [SEL_W-1:0]  sel_q;
  logic [LANE_W-1:0] lanes_q;
  logic              last_pend;
  logic              live_valid, held_valid;
  logic [ROW_W-1:0]  held_row;
  logic [MAT_SIZE-1:0] final_mask;
  logic              load, accept, drop, clr_drop;
  logic [AWIDTH-1:0] next_addr;
  logic              last_row;

  wb_addr_gen #(
    .AWIDTH(AWIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .advance  (accept),
    .base_addr(base_addr),
    .stride   (stride),
    .num_rows (num_rows),
    .next_addr(next_addr),
    .last_row (last_row)
  );

  // live_valid uses the port select (no job latched yet in IDLE);
  // held_valid/held_row use the select captured at job start.
  always_comb begin
    live_valid = 1'b0;
    held_valid = 1'b0;
    held_row   = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (src_sel == SEL_W'(s)) live_valid = src_valid[s];
      if (sel_q == SEL_W'(s)) begin
        held_valid = src_valid[s];
        held_row   = src_data[s*ROW_W +: ROW_W];
      end
    end
  end

  always_comb begin
    final_mask = '1;
    if (lanes_q >= LANE_W'(1) && lanes_q <= LANE_W'(MAT_SIZE)) begin
      for (int l = 0; l < MAT_SIZE; l++) final_mask[l] = (LANE_W'(l) < lanes_q);
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accept    = 1'b0;
    drop      = 1'b0;
    clr_drop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          clr_drop  = 1'b1;
          state_nxt = (num_rows != 8'd0) ? ST_ACTIVE : ST_DONE;
        end else if (live_valid) begin
          drop = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // last_pend marks the cycle the final write is on the bus.
        if (last_pend) state_nxt = ST_DONE;
        else if (held_valid) accept = 1'b1;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        if (held_valid) drop = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      sel_q      <= '0;
      lanes_q    <= '0;
      last_pend  <= 1'b0;
      drop_err   <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      bram_we    <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        sel_q   <= src_sel;
        lanes_q <= last_lanes;
      end
      if (load)                   last_pend <= 1'b0;
      else if (accept && last_row) last_pend <= 1'b1;
      else if (state != ST_ACTIVE) last_pend <= 1'b0;
      if (clr_drop)  drop_err <= 1'b0;
      else if (drop) drop_err <= 1'b1;
      if (accept) begin
        bram_addr  <= next_addr;
        bram_wdata <= held_row;
        bram_we    <= last_row ? final_mask : '1;
      end else begin
        bram_wdata <= '0;
        bram_we    <= '0;
      end
    end
  end

  assign bram_en = 1'b1;
  assign busy    = (state == ST_ACTIVE) || (state == ST_DONE);
  assign done    = (state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_result_writeback.sv
// Scoreboard bench for result_writeback: expected writes are queued as rows
// are driven and checked as the BRAM port shows them.
`default_nettype none

module tb_result_writeback;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [9:0]  stride = '0;
  logic [7:0]  num_rows = '0;
  logic [2:0]  last_lanes = '0;
  logic [1:0]  src_sel = '0;
  logic [127:0] src_data = '0;
  logic [3:0]  src_valid = '0;
  logic [9:0]  bram_addr;
  logic [31:0] bram_wdata;
  logic [3:0]  bram_we;
  logic        bram_en, busy, done, drop_err;

  result_writeback dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .stride(stride), .num_rows(num_rows), .last_lanes(last_lanes),
    .src_sel(src_sel), .src_data(src_data), .src_valid(src_valid),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we),
    .bram_en(bram_en), .busy(busy), .done(done), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  we;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_writes = 0;
  int n_done = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  logic mon_on = 1'b0;

  logic [9:0] m_addr, m_stride;
  int   m_row, m_rows, m_lanes, m_sel;
  logic m_active = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_on) begin
      check("bram_en", bram_en, 1);
      if (bram_we != 4'd0) begin
        n_writes++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_write", bram_we, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_addr", bram_addr, e.addr);
          check("wr_data", bram_wdata, e.data);
          check("wr_we", bram_we, e.we);
        end
      end else begin
        check("idle_wdata", bram_wdata, 0);
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [9:0] b, input logic [9:0] s, input int rows,
                           input int lanes, input int sel);
    base_addr = b; stride = s; num_rows = 8'(rows); last_lanes = 3'(lanes);
    src_sel = 2'(sel); start = 1'b1;
    m_addr = b; m_stride = s; m_rows = rows; m_row = 0; m_lanes = lanes; m_sel = sel;
    m_active = (rows > 0);
    tick();
    start = 1'b0;
  endtask

  // Drive one cycle of valids on the sources in vmask, each with its own data.
  task automatic drive_multi(input logic [3:0] vmask);
    exp_t e;
    for (int s = 0; s < 4; s++) src_data[s*32 +: 32] = $urandom;
    src_valid = vmask;
    if (m_active && vmask[m_sel] && m_row < m_rows) begin
      e.addr = m_addr;
      e.data = src_data[m_sel*32 +: 32];
      if (m_row == m_rows - 1 && m_lanes >= 1 && m_lanes <= 4) e.we = 4'hF >> (4 - m_lanes);
      else e.we = 4'hF;
      exp_q.push_back(e);
      m_addr = m_addr + m_stride;
      m_row++;
      if (m_row == m_rows) m_active = 1'b0;
    end
    tick();
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 20 && n_done < target; k++) tick();
    check("done_seen", (n_done >= target), 1);
  endtask

  int w0, d0;

  initial begin
    reset = 1'b1;
    tick(); mon_on = 1'b1; tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_drop", drop_err, 0);
    check("rst_we", bram_we, 0);
    check("rst_addr", bram_addr, 0);
    check("rst_wdata", bram_wdata, 0);
    reset = 1'b0;
    tick();

    // Four back-to-back norm rows up to the top of memory; a stray start mid-job.
    w0 = n_writes; d0 = n_done;
    start_job(10'h3F0, 10'd4, 4, 4, 1);
    check("busy_active", busy, 1);
    drive_multi(4'b0010);
    start = 1'b1; base_addr = 10'h100;
    drive_multi(4'b0010);
    start = 1'b0;
    drive_multi(4'b0010);
    drive_multi(4'b0010);
    src_valid = '0;
    wait_done(d0 + 1);
    check("done_latency", done_cyc - last_wr_cyc, 1);
    check("t1_writes", n_writes - w0, 4);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_done", done, 0);

    // Address wrap.
    w0 = n_writes; d0 = n_done;
    start_job(10'h3FC, 10'd4, 2, 4, 0);
    drive_multi(4'b0001);
    drive_multi(4'b0001);
    src_valid = '0;
    wait_done(d0 + 1);
    check("t2_writes", n_writes - w0, 2);

    // Partial final row, with gaps between rows.
    w0 = n_writes; d0 = n_done;
    start_job(10'h020, 10'd8, 3, 2, 3);
    drive_multi(4'b1000);
    src_valid = '0; tick();
    drive_multi(4'b1000);
    src_valid = '0; tick(); tick();
    drive_multi(4'b1000);
    src_valid = '0;
    wait_done(d0 + 1);
    check("t3_writes", n_writes - w0, 3);

    // Only source 2 is written despite traffic on the others.
    w0 = n_writes; d0 = n_done;
    start_job(10'h080, 10'd1, 2, 4, 2);
    drive_multi(4'b0001);
    drive_multi(4'b1010);
    drive_multi(4'b1111);
    src_valid = '0; tick();
    drive_multi(4'b1011);
    drive_multi(4'b0111);
    src_valid = '0;
    wait_done(d0 + 1);
    check("t4_writes", n_writes - w0, 2);

    // Drop error in IDLE, cleared by a zero-row start; drop again in DONE.
    w0 = n_writes; d0 = n_done;
    check("t5_drop_pre", drop_err, 0);
    drive_multi(4'b0100);
    src_valid = '0;
    check("t5_drop_set", drop_err, 1);
    tick();
    start_job(10'h000, 10'd1, 0, 4, 2);
    check("t5_done_now", done, 1);
    check("t5_drop_clr", drop_err, 0);
    check("t5_busy_done", busy, 1);
    drive_multi(4'b0100);
    src_valid = '0;
    check("t5_done_gone", done, 0);
    check("t5_drop_done", drop_err, 1);
    tick(); tick();
    check("t5_writes", n_writes - w0, 0);
    check("t5_dones", n_done - d0, 1);

    // Reset in the middle of a four-row job.
    w0 = n_writes; d0 = n_done;
    start_job(10'h010, 10'd1, 4, 4, 0);
    check("t6_drop_clr", drop_err, 0);
    drive_multi(4'b0001);
    drive_multi(4'b0001);
    reset = 1'b1;
    src_valid = 4'b0001;
    tick();
    check("t6_rst_we", bram_we, 0);
    check("t6_rst_addr", bram_addr, 0);
    check("t6_rst_wdata", bram_wdata, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    reset = 1'b0;
    src_valid = '0;
    m_active = 1'b0;
    repeat (6) tick();
    check("t6_writes", n_writes - w0, 2);
    check("t6_no_done", n_done - d0, 0);
    check("t6_busy", busy, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
